// File: rtl/mul_seq_ctrl.sv
// Sequential 6-bit signed shift-add multiplier.
// Sign-magnitude core: 5 iterations, truncated 6-bit result plus overflow flag.
module mul_seq_ctrl #(
  parameter int N_ITER = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [5:0] A,
  input  logic [5:0] B,
  output logic [5:0] M,
  output logic       OF_MUL,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [5:0] a_q, b_q;
  logic [4:0] ma, mb;
  logic       sign;
  logic [9:0] acc;
  logic [2:0] cnt;
  logic [5:0] neg_a, neg_b;
  logic [5:0] prod_lo, m_fix;

  assign neg_a   = ~a_q + 6'd1;
  assign neg_b   = ~b_q + 6'd1;
  assign prod_lo = {1'b0, acc[4:0]};
  assign m_fix   = sign ? (~prod_lo + 6'd1) : prod_lo;

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (START) state_n = S_LOAD;
      S_LOAD: state_n = S_ITER;
      S_ITER: if (cnt == 3'(N_ITER - 1)) state_n = S_FIX;
      S_FIX:  state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q    <= '0;
      b_q    <= '0;
      ma     <= '0;
      mb     <= '0;
      sign   <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      M      <= '0;
      OF_MUL <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (START) begin
            a_q <= A;
            b_q <= B;
          end
        end
        S_LOAD: begin
          // -32 negates to itself, so its low five bits give magnitude 0
          ma   <= a_q[5] ? neg_a[4:0] : a_q[4:0];
          mb   <= b_q[5] ? neg_b[4:0] : b_q[4:0];
          sign <= a_q[5] ^ b_q[5];
          acc  <= '0;
          cnt  <= '0;
        end
        S_ITER: begin
          if (mb[cnt]) acc <= acc + (10'(ma) << cnt);
          cnt <= cnt + 3'd1;
        end
        S_FIX: begin
          M      <= m_fix;
          OF_MUL <= |acc[9:5];
        end
        default: ;
      endcase
    end
  end

  assign BUSY = (state == S_LOAD) || (state == S_ITER) || (state == S_FIX);
  assign DONE = (state == S_DONE);

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl.
// Directed and random operands against an arithmetic reference.
module tb_mul_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic [5:0] A = '0;
  logic [5:0] B = '0;
  logic [5:0] M;
  logic       OF_MUL;
  logic       BUSY;
  logic       DONE;

  int n_chk = 0;
  int n_fail = 0;

  mul_seq_ctrl #(.N_ITER(5)) dut (
    .CLK(CLK),
    .RST(RST),
    .START(START),
    .A(A),
    .B(B),
    .M(M),
    .OF_MUL(OF_MUL),
    .BUSY(BUSY),
    .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // {of, m} from plain signed arithmetic
  function automatic logic [6:0] ref_mul(input logic [5:0] a,
                                         input logic [5:0] b);
    int sa, sb, ma, mb, p, lo, mv;
    logic [5:0] m6;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ma = (sa < 0 ? -sa : sa) % 32;
    mb = (sb < 0 ? -sb : sb) % 32;
    p  = ma * mb;
    lo = p % 32;
    mv = (a[5] ^ b[5]) ? (64 - lo) % 64 : lo;
    m6 = 6'(mv);
    return {p >= 32, m6};
  endfunction

  task automatic run_op(input logic [5:0] a, input logic [5:0] b,
                        input bit scramble);
    int n, busy_n;
    bit got;
    logic [6:0] exp;
    exp = ref_mul(a, b);
    A = a;
    B = b;
    START = 1'b1;
    tick();
    START = 1'b0;
    n = 0;
    busy_n = 0;
    got = 0;
    while (!got && n < 20) begin
      if (BUSY) busy_n++;
      if (DONE) got = 1;
      else begin
        if (scramble) begin
          A = 6'($urandom);
          B = 6'($urandom);
        end
        tick();
        n++;
      end
    end
    chk("done_seen", 32'(got), 32'd1);
    if (got) begin
      chk("latency", 32'(n), 32'd7);
      chk("busy_len", 32'(busy_n), 32'd7);
      chk($sformatf("m a=%h b=%h", a, b), 32'(M), 32'(exp[5:0]));
      chk($sformatf("of a=%h b=%h", a, b), 32'(OF_MUL), 32'(exp[6]));
      tick();
      chk("done_pulse", 32'(DONE), 32'd0);
      chk("idle_busy", 32'(BUSY), 32'd0);
      chk("m_hold", 32'(M), 32'(exp[5:0]));
    end
  endtask

  logic [5:0] dir_a [8] = '{6'o03, 6'o75, 6'o06, 6'o10,
                            6'o40, 6'o37, 6'o00, 6'o40};
  logic [5:0] dir_b [8] = '{6'o05, 6'o04, 6'o73, 6'o04,
                            6'o07, 6'o37, 6'o75, 6'o40};

  initial begin
    int last, gap_bad, dones;
    logic [6:0] exp;

    RST = 1'b1;
    tick();
    tick();
    chk("rst_m", 32'(M), 32'd0);
    chk("rst_of", 32'(OF_MUL), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    RST = 1'b0;

    run_op(6'b000011, 6'b000101, 0);
    chk("basic_m", 32'(M), 32'h0f);
    run_op(6'b111101, 6'b000100, 0);
    chk("neg_m", 32'(M), 32'h34);
    run_op(6'b000110, 6'b111011, 0);
    chk("p30_m", 32'(M), 32'h22);
    run_op(6'b001000, 6'b000100, 0);
    chk("p32_of", 32'(OF_MUL), 32'd1);
    run_op(6'b011111, 6'b011111, 0);
    chk("p961_m", 32'(M), 32'h01);

    foreach (dir_a[i]) run_op(dir_a[i], dir_b[i], 1);
    for (int i = 0; i < 40; i++)
      run_op(6'($urandom), 6'($urandom), 1);

    // START held high: exactly one DONE per operation, never adjacent
    A = 6'b000111;
    B = 6'b111010;
    exp = ref_mul(A, B);
    START = 1'b1;
    last = -1;
    gap_bad = 0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (DONE) begin
        dones++;
        chk("held_m", 32'(M), 32'(exp[5:0]));
        if (last >= 0 && c - last != 9) gap_bad++;
        last = c;
      end
    end
    START = 1'b0;
    chk("held_dones", 32'(dones), 32'd4);
    chk("held_gap", 32'(gap_bad), 32'd0);
    for (int c = 0; c < 12; c++) tick();

    // Reset abort while iterating
    A = 6'b001011;
    B = 6'b000111;
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_busy_pre", 32'(BUSY), 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_m", 32'(M), 32'd0);
    chk("abort_of", 32'(OF_MUL), 32'd0);
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      if (DONE) dones++;
      tick();
    end
    chk("abort_no_done", 32'(dones), 32'd0);

    // START on the first edge after reset release
    RST = 1'b1;
    tick();
    RST = 1'b0;
    run_op(6'b000101, 6'b111101, 0);
    chk("post_rst_m", 32'(M), 32'h31);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
